// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store memory master.
package lsu_pkg;

  typedef enum logic [1:0] {
    BYTE    = 2'b00,
    HALF    = 2'b01,
    WORD    = 2'b10,
    ILLEGAL = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD0  = 3'd1,
    WR0  = 3'd2,
    RD1  = 3'd3,
    WR1  = 3'd4,
    RESP = 3'd5
  } state_t;

  typedef logic [7:0] byte_lanes_t [0:3];

  function automatic logic [2:0] size_bytes(input size_t size);
    logic [2:0] n;
    case (size)
      BYTE:    n = 3'd1;
      HALF:    n = 3'd2;
      WORD:    n = 3'd4;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] data, input size_t size,
                                         input logic is_unsigned);
    logic [31:0] r;
    case (size)
      BYTE:    r = {{24{~is_unsigned & data[7]}}, data[7:0]};
      HALF:    r = {{16{~is_unsigned & data[15]}}, data[15:0]};
      WORD:    r = data;
      default: r = 32'd0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_master_if.sv
// Request/response and word-memory signals of the load/store master.
interface lsu_mem_master_if;
  import lsu_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  byte_lanes_t mem_wdata;
  logic        mem_we;
  byte_lanes_t mem_rdata;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_lane_merge.sv
// Maps access bytes onto the lanes of the first or second memory word:
// lane enables plus the current word with the enabled lanes replaced by store data.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  byte_lanes_t cur,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  n,
  input  logic        second,
  output byte_lanes_t merged,
  output logic [3:0]  be
);

  logic [2:0] pos_s [0:3];

  // Access byte index per lane; lanes left of the offset wrap to 5..7 and fall outside n.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pos_s[i] = 3'(i) - {1'b0, off} + (second ? 3'd4 : 3'd0);
      be[i]    = (pos_s[i] < n);
      if (be[i]) begin
        merged[i] = wdata[{pos_s[i][1:0], 3'b000} +: 8];
      end else begin
        merged[i] = cur[i];
      end
    end
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Byte/half/word load-store initiator issuing word-aligned memory accesses,
// with read-modify-write for partial stores and splitting of word-crossing accesses.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int unsigned MISALIGN_EN = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  lsu_mem_master_if.master bus
);

  state_t      state_r;
  logic        we_r;
  logic        uns_r;
  logic        cross_r;
  size_t       size_r;
  logic [1:0]  off_r;
  logic [2:0]  n_r;
  logic [31:0] w0_r;
  logic [31:0] wdata_r;
  logic [31:0] data_r;
  logic        req_ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_rdata_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  byte_lanes_t mem_wdata_r;

  size_t       req_size_s;
  logic [1:0]  req_off_s;
  logic [2:0]  req_n_s;
  logic        req_err_s;
  logic        second_s;
  byte_lanes_t merged_s;
  logic [3:0]  be_s;
  logic [1:0]  lane_s [0:3];
  logic [31:0] load_s;

  // Decode the incoming request and flag illegal sizes or rejected misalignment.
  always_comb begin
    req_size_s = size_t'(bus.req_size);
    req_off_s  = bus.req_addr[1:0];
    req_n_s    = size_bytes(req_size_s);
    if (req_size_s == ILLEGAL) begin
      req_err_s = 1'b1;
    end else if ((MISALIGN_EN == 32'd0) && (({1'b0, req_off_s} & (req_n_s - 3'd1)) != 3'd0)) begin
      req_err_s = 1'b1;
    end else begin
      req_err_s = 1'b0;
    end
  end

  assign second_s = (state_r == RD1);

  lsu_lane_merge u_lane_merge (
    .cur    (bus.mem_rdata),
    .wdata  (wdata_r),
    .off    (off_r),
    .n      (n_r),
    .second (second_s),
    .merged (merged_s),
    .be     (be_s)
  );

  // Fold the enabled lanes of the word being read into the load accumulator.
  always_comb begin
    load_s = data_r;
    for (int k = 0; k < 4; k++) begin
      lane_s[k] = 2'(k) + off_r;
      if (be_s[lane_s[k]]) begin
        load_s[8*k +: 8] = bus.mem_rdata[lane_s[k]];
      end else begin
        load_s[8*k +: 8] = data_r[8*k +: 8];
      end
    end
  end

  // Request sequencing FSM with registered handshake and memory outputs.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      uns_r       <= 1'b0;
      cross_r     <= 1'b0;
      size_r      <= BYTE;
      off_r       <= 2'd0;
      n_r         <= 3'd0;
      w0_r        <= 32'd0;
      wdata_r     <= 32'd0;
      data_r      <= 32'd0;
      req_ready_r <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_err_r   <= 1'b0;
      rsp_rdata_r <= 32'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'd0;
      for (int i = 0; i < 4; i++) mem_wdata_r[i] <= 8'd0;
    end else begin
      rsp_valid_r <= 1'b0;
      mem_we_r    <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            we_r        <= bus.req_we;
            size_r      <= req_size_s;
            uns_r       <= bus.req_unsigned;
            off_r       <= req_off_s;
            n_r         <= req_n_s;
            cross_r     <= (({1'b0, req_off_s} + req_n_s) > 3'd4);
            w0_r        <= {bus.req_addr[31:2], 2'b00};
            wdata_r     <= bus.req_wdata;
            data_r      <= 32'd0;
            req_ready_r <= 1'b0;
            if (req_err_s) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_err_r   <= 1'b1;
              rsp_rdata_r <= 32'd0;
            end else if (bus.req_we && (req_size_s == WORD) && (req_off_s == 2'd0)) begin
              // Full aligned word overwrites every lane, so no read is needed.
              state_r    <= WR0;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
              mem_we_r   <= 1'b1;
              for (int i = 0; i < 4; i++) mem_wdata_r[i] <= bus.req_wdata[8*i +: 8];
            end else begin
              state_r    <= RD0;
              mem_addr_r <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        RD0, RD1: begin
          if (we_r) begin
            state_r     <= (state_r == RD0) ? WR0 : WR1;
            mem_we_r    <= 1'b1;
            mem_wdata_r <= merged_s;
          end else if ((state_r == RD0) && cross_r) begin
            state_r    <= RD1;
            data_r     <= load_s;
            mem_addr_r <= w0_r + 32'd4;
          end else begin
            state_r     <= RESP;
            data_r      <= load_s;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= extend(load_s, size_r, uns_r);
          end
        end
        WR0, WR1: begin
          if ((state_r == WR0) && cross_r) begin
            state_r    <= RD1;
            mem_addr_r <= w0_r + 32'd4;
          end else begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_err_r   <= 1'b0;
            rsp_rdata_r <= 32'd0;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  // Reset gates the write strobe immediately so an aborted store commits nothing.
  assign bus.mem_we    = mem_we_r & rst_b;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Directed bench: two masters (misalignment split / reject) each on a 256-byte memory model.
module tb_lsu_mem_master;
  import lsu_pkg::*;

  typedef struct {
    bit          sel;
    bit          we;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_nwe;
    int          exp_we1;
  } vec_t;

  logic clk;
  logic rst_b;
  logic init_mem;
  logic sel_b;
  logic req_valid, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [7:0]  mem_a [0:255];
  logic [7:0]  mem_b [0:255];

  int n_chk = 0;
  int n_fail = 0;
  vec_t vecs [0:25];

  lsu_mem_master_if ifa ();
  lsu_mem_master_if ifb ();

  lsu_mem_master #(.MISALIGN_EN(1)) dut_a (.clk(clk), .rst_b(rst_b), .bus(ifa));
  lsu_mem_master #(.MISALIGN_EN(0)) dut_b (.clk(clk), .rst_b(rst_b), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ifa.req_valid    = req_valid & ~sel_b;
  assign ifb.req_valid    = req_valid & sel_b;
  assign ifa.req_we       = req_we;
  assign ifb.req_we       = req_we;
  assign ifa.req_size     = req_size;
  assign ifb.req_size     = req_size;
  assign ifa.req_unsigned = req_unsigned;
  assign ifb.req_unsigned = req_unsigned;
  assign ifa.req_addr     = req_addr;
  assign ifb.req_addr     = req_addr;
  assign ifa.req_wdata    = req_wdata;
  assign ifb.req_wdata    = req_wdata;

  wire        rdy_m    = sel_b ? ifb.req_ready : ifa.req_ready;
  wire        vld_m    = sel_b ? ifb.rsp_valid : ifa.rsp_valid;
  wire [31:0] rdata_m  = sel_b ? ifb.rsp_rdata : ifa.rsp_rdata;
  wire        err_m    = sel_b ? ifb.rsp_err   : ifa.rsp_err;
  wire        mem_we_m = sel_b ? ifb.mem_we    : ifa.mem_we;

  function automatic logic [7:0] init_byte(input int a);
    case (a)
      8'h08:   return 8'h01;
      8'h09:   return 8'h7F;
      8'h0A:   return 8'hFF;
      8'h0B:   return 8'h80;
      8'h0C:   return 8'h55;
      8'h0D:   return 8'h66;
      8'h0E:   return 8'h77;
      8'h0F:   return 8'h88;
      8'hFF:   return 8'h9A;
      8'h00:   return 8'hBC;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ifa.mem_rdata[i] = mem_a[8'(ifa.mem_addr[7:0] + 8'(i))];
      ifb.mem_rdata[i] = mem_b[8'(ifb.mem_addr[7:0] + 8'(i))];
    end
  end

  always @(posedge clk) begin
    if (init_mem) begin
      for (int a = 0; a < 256; a++) begin
        mem_a[a] <= init_byte(a);
        mem_b[a] <= init_byte(a);
      end
    end else begin
      if (ifa.mem_we) for (int i = 0; i < 4; i++) mem_a[8'(ifa.mem_addr[7:0] + 8'(i))] <= ifa.mem_wdata[i];
      if (ifb.mem_we) for (int i = 0; i < 4; i++) mem_b[8'(ifb.mem_addr[7:0] + 8'(i))] <= ifb.mem_wdata[i];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit sel, input bit we, input logic [1:0] size, input bit uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] exp_rdata, input bit exp_err,
                              input int exp_lat, input int exp_nwe, input int exp_we1);
    vec_t v;
    v.sel = sel; v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    v.exp_nwe = exp_nwe; v.exp_we1 = exp_we1;
    return v;
  endfunction

  task automatic run_vec(input int idx, input vec_t v);
    int lat, nwe, we1;
    bit got;
    @(negedge clk);
    sel_b = v.sel; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata; req_valid = 1'b1;
    chk($sformatf("v%0d_ready", idx), 32'(rdy_m), 32'd1);
    @(posedge clk);
    #1;
    // Scramble request fields after accept; they must be ignored.
    req_valid = 1'b0; req_we = ~v.we; req_size = ~v.size; req_unsigned = ~v.uns;
    req_addr = ~v.addr; req_wdata = ~v.wdata;
    got = 1'b0; lat = 0; nwe = 0; we1 = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (mem_we_m) begin
        nwe++;
        if (we1 == 0) we1 = c;
      end
      if (vld_m) begin
        got = 1'b1;
        lat = c;
      end
    end
    chk($sformatf("v%0d_latency", idx), 32'(lat), 32'(v.exp_lat));
    chk($sformatf("v%0d_rdata", idx), rdata_m, v.exp_rdata);
    chk($sformatf("v%0d_err", idx), 32'(err_m), 32'(v.exp_err));
    chk($sformatf("v%0d_we_pulses", idx), 32'(nwe), 32'(v.exp_nwe));
    chk($sformatf("v%0d_first_we", idx), 32'(we1), 32'(v.exp_we1));
    chk($sformatf("v%0d_ready_in_resp", idx), 32'(rdy_m), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d_pulse_end", idx), 32'(vld_m), 32'd0);
    chk($sformatf("v%0d_ready_idle", idx), 32'(rdy_m), 32'd1);
    chk($sformatf("v%0d_rdata_held", idx), rdata_m, v.exp_rdata);
  endtask

  initial begin
    rst_b = 1'b0; init_mem = 1'b1; sel_b = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'b00; req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;

    // sel we size uns addr wdata exp_rdata err lat nwe we1
    vecs[0]  = mk(0, 0, 2'b00, 0, 32'h0000_000A, 32'h0, 32'hFFFF_FFFF, 0, 2, 0, 0);
    vecs[1]  = mk(0, 0, 2'b00, 1, 32'h0000_000A, 32'h0, 32'h0000_00FF, 0, 2, 0, 0);
    vecs[2]  = mk(0, 0, 2'b01, 0, 32'h0000_000A, 32'h0, 32'hFFFF_80FF, 0, 2, 0, 0);
    vecs[3]  = mk(0, 0, 2'b10, 0, 32'h0000_0008, 32'h0, 32'h80FF_7F01, 0, 2, 0, 0);
    vecs[4]  = mk(0, 0, 2'b01, 1, 32'h0000_0009, 32'h0, 32'h0000_FF7F, 0, 2, 0, 0);
    vecs[5]  = mk(0, 0, 2'b01, 0, 32'h0000_000B, 32'h0, 32'h0000_5580, 0, 3, 0, 0);
    vecs[6]  = mk(0, 1, 2'b00, 0, 32'h0000_0009, 32'h1234_56AA, 32'h0, 0, 3, 1, 2);
    vecs[7]  = mk(0, 0, 2'b10, 0, 32'h0000_0008, 32'h0, 32'h80FF_AA01, 0, 2, 0, 0);
    vecs[8]  = mk(0, 1, 2'b10, 0, 32'h0000_000A, 32'h1122_3344, 32'h0, 0, 5, 2, 2);
    vecs[9]  = mk(0, 0, 2'b10, 0, 32'h0000_000A, 32'h0, 32'h1122_3344, 0, 3, 0, 0);
    vecs[10] = mk(0, 0, 2'b10, 0, 32'h0000_0008, 32'h0, 32'h3344_AA01, 0, 2, 0, 0);
    vecs[11] = mk(0, 0, 2'b10, 0, 32'h0000_000C, 32'h0, 32'h8877_1122, 0, 2, 0, 0);
    vecs[12] = mk(0, 1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 2, 1, 1);
    vecs[13] = mk(0, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 0, 2, 0, 0);
    vecs[14] = mk(0, 1, 2'b01, 0, 32'h0000_0013, 32'h0000_CAFE, 32'h0, 0, 5, 2, 2);
    vecs[15] = mk(0, 0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hFEAD_BEEF, 0, 2, 0, 0);
    vecs[16] = mk(0, 0, 2'b00, 0, 32'h0000_0014, 32'h0, 32'hFFFF_FFCA, 0, 2, 0, 0);
    vecs[17] = mk(0, 0, 2'b01, 1, 32'hFFFF_FFFF, 32'h0, 32'h0000_BC9A, 0, 3, 0, 0);
    vecs[18] = mk(0, 0, 2'b00, 0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FF9A, 0, 2, 0, 0);
    vecs[19] = mk(0, 0, 2'b11, 0, 32'h0000_0008, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[20] = mk(1, 0, 2'b01, 0, 32'h0000_000B, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[21] = mk(1, 1, 2'b11, 0, 32'h0000_0008, 32'h5555_5555, 32'h0, 1, 1, 0, 0);
    vecs[22] = mk(1, 0, 2'b10, 0, 32'h0000_0009, 32'h0, 32'h0, 1, 1, 0, 0);
    vecs[23] = mk(1, 0, 2'b10, 0, 32'h0000_0008, 32'h0, 32'h80FF_7F01, 0, 2, 0, 0);
    vecs[24] = mk(1, 1, 2'b01, 0, 32'h0000_000A, 32'h0000_BEEF, 32'h0, 0, 3, 1, 2);
    vecs[25] = mk(1, 0, 2'b01, 0, 32'h0000_000A, 32'h0, 32'hFFFF_BEEF, 0, 2, 0, 0);

    repeat (3) @(posedge clk);
    #1 rst_b = 1'b1; init_mem = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ifa.req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("reset_rsp_rdata", ifa.rsp_rdata, 32'd0);
    chk("reset_rsp_err", 32'(ifa.rsp_err), 32'd0);
    chk("reset_mem_addr", ifa.mem_addr, 32'd0);
    chk("reset_mem_we", 32'(ifa.mem_we), 32'd0);

    for (int i = 0; i < 26; i++) run_vec(i, vecs[i]);

    // Reset during the write cycle of a sub-word store.
    @(negedge clk);
    sel_b = 1'b0; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0000_0009; req_wdata = 32'h0000_0077; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 rst_b = 1'b0;
    @(negedge clk);
    chk("rst_we_gated", 32'(ifa.mem_we), 32'd0);
    @(posedge clk);
    #1 rst_b = 1'b1;
    @(negedge clk);
    chk("rst_mem_unchanged", 32'(mem_a[9]), 32'h0000_00AA);
    chk("rst_ready", 32'(ifa.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    chk("rst_rsp_err", 32'(ifa.rsp_err), 32'd0);
    chk("rst_rsp_rdata", ifa.rsp_rdata, 32'd0);
    chk("rst_mem_addr", ifa.mem_addr, 32'd0);
    chk("rst_mem_we", 32'(ifa.mem_we), 32'd0);
    chk("rst_mem_wdata", {ifa.mem_wdata[3], ifa.mem_wdata[2], ifa.mem_wdata[1], ifa.mem_wdata[0]}, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("rst_no_rsp_%0d", c), 32'(ifa.rsp_valid), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
